// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences the shared-memory datapath, handles the memory ready handshake with timeout.
// Optional J-type support is enabled by defining MULTICYCLE_JUMP_EN.
module multicycle_control #(
    parameter int MAX_WAIT = 255,
    parameter int WAIT_W   = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       iord,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [3:0] ALU_Control,
    output logic [1:0] pc_source,
    output logic [3:0] state,
    output logic       instr_done,
    output logic       illegal,
    output logic       bus_error
);

    typedef enum logic [3:0] {
        FETCH     = 4'd0,
        DECODE    = 4'd1,
        MEM_ADDR  = 4'd2,
        MEM_READ  = 4'd3,
        MEM_WB    = 4'd4,
        MEM_WRITE = 4'd5,
        EXECUTE   = 4'd6,
        ALU_WB    = 4'd7,
        BRANCH    = 4'd8
`ifdef MULTICYCLE_JUMP_EN
        , JUMP    = 4'd9
`endif
    } state_t;

    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    state_t            cur_state;
    state_t            next_state;
    logic [WAIT_W-1:0] wait_cnt;
    logic              is_wait_state;
    logic              timeout;
    logic              set_illegal;

    assign state         = cur_state;
    assign is_wait_state = (cur_state == FETCH) || (cur_state == MEM_READ) ||
                           (cur_state == MEM_WRITE);
    assign timeout       = is_wait_state && !mem_ready && (wait_cnt == WAIT_W'(MAX_WAIT));

    always_comb begin
        next_state  = cur_state;
        set_illegal = 1'b0;
        pc_write    = 1'b0;
        iord        = 1'b0;
        mem_read    = 1'b0;
        mem_write   = 1'b0;
        ir_write    = 1'b0;
        reg_dst     = 1'b0;
        mem_to_reg  = 1'b0;
        reg_write   = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        ALU_Control = ALU_ADD;
        pc_source   = 2'b00;
        instr_done  = 1'b0;

        case (cur_state)
            FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                if (mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    next_state = DECODE;
                end
            end
            DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    6'b000000:            next_state = EXECUTE;
                    6'b100011, 6'b101011: next_state = MEM_ADDR;
                    6'b000100:            next_state = BRANCH;
`ifdef MULTICYCLE_JUMP_EN
                    6'b000010:            next_state = JUMP;
`endif
                    default: begin
                        next_state  = FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            MEM_ADDR: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                next_state = (opcode == 6'b101011) ? MEM_WRITE : MEM_READ;
            end
            MEM_READ: begin
                iord     = 1'b1;
                mem_read = 1'b1;
                if (mem_ready)    next_state = MEM_WB;
                else if (timeout) next_state = FETCH;
            end
            MEM_WB: begin
                mem_to_reg = 1'b1;
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            MEM_WRITE: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                if (mem_ready || timeout) next_state = FETCH;
            end
            EXECUTE: begin
                alu_src_a  = 1'b1;
                next_state = ALU_WB;
                case (funct)
                    6'b100000: ALU_Control = ALU_ADD;
                    6'b100010: ALU_Control = ALU_SUB;
                    6'b100100: ALU_Control = ALU_AND;
                    6'b100101: ALU_Control = ALU_OR;
                    6'b101010: ALU_Control = ALU_SLT;
                    6'b100111: ALU_Control = ALU_NOR;
                    default: begin
                        next_state  = FETCH;
                        set_illegal = 1'b1;
                    end
                endcase
            end
            ALU_WB: begin
                reg_dst    = 1'b1;
                reg_write  = 1'b1;
                next_state = FETCH;
            end
            BRANCH: begin
                alu_src_a   = 1'b1;
                ALU_Control = ALU_SUB;
                pc_source   = 2'b01;
                pc_write    = zero;
                next_state  = FETCH;
            end
`ifdef MULTICYCLE_JUMP_EN
            JUMP: begin
                pc_source  = 2'b10;
                pc_write   = 1'b1;
                next_state = FETCH;
            end
`endif
            default: next_state = FETCH;
        endcase

        instr_done = (cur_state != FETCH) && (next_state == FETCH);

        // Strobes and selects must be inactive the moment reset rises, not one edge later.
        if (reset) begin
            pc_write    = 1'b0;
            iord        = 1'b0;
            mem_read    = 1'b0;
            mem_write   = 1'b0;
            ir_write    = 1'b0;
            reg_dst     = 1'b0;
            mem_to_reg  = 1'b0;
            reg_write   = 1'b0;
            alu_src_a   = 1'b0;
            alu_src_b   = 2'b00;
            ALU_Control = 4'b0000;
            pc_source   = 2'b00;
            instr_done  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state <= FETCH;
            wait_cnt  <= '0;
            illegal   <= 1'b0;
            bus_error <= 1'b0;
        end else begin
            cur_state <= next_state;
            if (set_illegal) illegal <= 1'b1;
            if (timeout) bus_error <= 1'b1;
            // Abort also clears the count so a FETCH retry starts a fresh wait window.
            if (!is_wait_state || mem_ready || timeout || (next_state != cur_state))
                wait_cnt <= '0;
            else
                wait_cnt <= wait_cnt + WAIT_W'(1);
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: state sequences, strobes, wait/timeout and sticky flags.
module tb_multicycle_control;

    logic       clk;
    logic       reset;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, iord, mem_read, mem_write, ir_write;
    logic       reg_dst, mem_to_reg, reg_write, alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] ALU_Control;
    logic [1:0] pc_source;
    logic [3:0] state;
    logic       instr_done, illegal, bus_error;

    int checks = 0;
    int errors = 0;

    multicycle_control #(.MAX_WAIT(4), .WAIT_W(3)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_write(pc_write), .iord(iord), .mem_read(mem_read),
        .mem_write(mem_write), .ir_write(ir_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .ALU_Control(ALU_Control), .pc_source(pc_source),
        .state(state), .instr_done(instr_done), .illegal(illegal), .bus_error(bus_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic mr);
        @(posedge clk);
        #1;
        mem_ready = mr;
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
    endtask

    task automatic run_rtype(input logic [5:0] f, input logic [3:0] ctl);
        opcode = 6'b000000; funct = f; mem_ready = 1'b1;
        #1;
        check_val("rt_fetch_state", state, 0);
        check_val("rt_fetch_irw", ir_write, 1);
        step(1);
        check_val("rt_decode_state", state, 1);
        check_val("rt_decode_srcb", alu_src_b, 2'b11);
        step(1);
        check_val("rt_exec_state", state, 6);
        check_val("rt_exec_aluctl", ALU_Control, ctl);
        check_val("rt_exec_regw", reg_write, 0);
        step(1);
        check_val("rt_wb_state", state, 7);
        check_val("rt_wb_regw", reg_write, 1);
        check_val("rt_wb_regdst", reg_dst, 1);
        check_val("rt_wb_done", instr_done, 1);
        step(1);
        check_val("rt_back_state", state, 0);
        check_val("rt_back_done", instr_done, 0);
    endtask

    logic [5:0] rt_funct [6] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b100111};
    logic [3:0] rt_ctl   [6] = '{4'b0010, 4'b0110, 4'b0000, 4'b0001, 4'b0111, 4'b1100};

    initial begin
        reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #2;
        check_val("rst_state", state, 0);
        check_val("rst_memread", mem_read, 0);
        check_val("rst_aluctl", ALU_Control, 0);
        check_val("rst_srcb", alu_src_b, 0);
        check_val("rst_illegal", illegal, 0);
        check_val("rst_buserr", bus_error, 0);
        reset = 1'b0;
        #1;
        check_val("fetch_memread", mem_read, 1);
        check_val("fetch_aluctl", ALU_Control, 4'b0010);

        for (int i = 0; i < 6; i++) run_rtype(rt_funct[i], rt_ctl[i]);

        // lw with three wait cycles in MEM_READ
        opcode = 6'b100011; mem_ready = 1'b1;
        #1;
        step(1);
        check_val("lw_decode", state, 1);
        step(1);
        check_val("lw_maddr", state, 2);
        check_val("lw_maddr_srcb", alu_src_b, 2'b10);
        check_val("lw_maddr_srca", alu_src_a, 1);
        for (int i = 0; i < 3; i++) begin
            step(0);
            check_val("lw_wait_state", state, 3);
            check_val("lw_wait_iord", iord, 1);
        end
        step(1);
        check_val("lw_ready_state", state, 3);
        step(1);
        check_val("lw_wb_state", state, 4);
        check_val("lw_wb_m2r", mem_to_reg, 1);
        check_val("lw_wb_regw", reg_write, 1);
        check_val("lw_wb_regdst", reg_dst, 0);
        check_val("lw_wb_done", instr_done, 1);
        step(1);
        check_val("lw_back", state, 0);
        check_val("lw_buserr", bus_error, 0);

        // sw
        opcode = 6'b101011;
        #1;
        step(1);
        step(1);
        check_val("sw_maddr", state, 2);
        step(1);
        check_val("sw_mw_state", state, 5);
        check_val("sw_mw_write", mem_write, 1);
        check_val("sw_mw_iord", iord, 1);
        check_val("sw_mw_done", instr_done, 1);
        step(1);
        check_val("sw_back", state, 0);

        // beq taken and not taken
        opcode = 6'b000100; zero = 1'b1;
        #1;
        step(1);
        step(1);
        check_val("beq1_state", state, 8);
        check_val("beq1_pcw", pc_write, 1);
        check_val("beq1_pcsrc", pc_source, 2'b01);
        check_val("beq1_aluctl", ALU_Control, 4'b0110);
        check_val("beq1_done", instr_done, 1);
        step(1);
        zero = 1'b0;
        #1;
        step(1);
        step(1);
        check_val("beq0_state", state, 8);
        check_val("beq0_pcw", pc_write, 0);
        step(1);
        check_val("beq0_back", state, 0);

        // illegal opcode, sticky across a valid instruction
        opcode = 6'b111111;
        #1;
        step(1);
        check_val("illop_decode", state, 1);
        check_val("illop_done", instr_done, 1);
        check_val("illop_pre", illegal, 0);
        step(1);
        check_val("illop_back", state, 0);
        check_val("illop_set", illegal, 1);
        run_rtype(6'b100000, 4'b0010);
        check_val("illop_sticky", illegal, 1);

        // reset asserted in MEM_WB
        opcode = 6'b100011;
        #1;
        step(1);
        step(1);
        step(1);
        step(1);
        check_val("rstwb_state", state, 4);
        check_val("rstwb_regw_pre", reg_write, 1);
        reset = 1'b1;
        #1;
        check_val("rstwb_regw", reg_write, 0);
        check_val("rstwb_memread", mem_read, 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check_val("rstwb_after", state, 0);
        check_val("rstwb_illegal", illegal, 0);

        // illegal funct
        opcode = 6'b000000; funct = 6'b111111;
        #1;
        step(1);
        step(1);
        check_val("illf_exec", state, 6);
        check_val("illf_done", instr_done, 1);
        check_val("illf_regw", reg_write, 0);
        step(1);
        check_val("illf_back", state, 0);
        check_val("illf_set", illegal, 1);

        // jump opcode
        do_reset();
        opcode = 6'b000010;
        #1;
        step(1);
        check_val("j_decode", state, 1);
`ifdef MULTICYCLE_JUMP_EN
        step(1);
        check_val("j_state", state, 9);
        check_val("j_pcw", pc_write, 1);
        check_val("j_pcsrc", pc_source, 2'b10);
        check_val("j_done", instr_done, 1);
        step(1);
        check_val("j_back", state, 0);
        check_val("j_illegal", illegal, 0);
`else
        check_val("j_done", instr_done, 1);
        step(1);
        check_val("j_back", state, 0);
        check_val("j_illegal", illegal, 1);
`endif

        // FETCH timeout with MAX_WAIT=4
        mem_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            check_val("tof_state", state, 0);
            check_val("tof_irw", ir_write, 0);
            check_val("tof_buserr_pre", bus_error, 0);
            step(0);
        end
        check_val("tof_abort_irw", ir_write, 0);
        check_val("tof_abort_pcw", pc_write, 0);
        check_val("tof_abort_done", instr_done, 0);
        step(0);
        check_val("tof_state_after", state, 0);
        check_val("tof_buserr", bus_error, 1);
        mem_ready = 1'b1;
        #1;
        check_val("tof_retry_irw", ir_write, 1);

        // MEM_READ timeout
        do_reset();
        opcode = 6'b100011; mem_ready = 1'b1;
        #1;
        step(1);
        step(1);
        step(0);
        check_val("tom_state", state, 3);
        for (int i = 0; i < 4; i++) step(0);
        check_val("tom_abort_state", state, 3);
        check_val("tom_abort_done", instr_done, 1);
        check_val("tom_abort_regw", reg_write, 0);
        check_val("tom_buserr_pre", bus_error, 0);
        step(1);
        check_val("tom_back", state, 0);
        check_val("tom_buserr", bus_error, 1);
        check_val("tom_back_regw", reg_write, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Moore/Mealy FSM that sequences a multi-cycle MIPS datapath: one shared memory, IR, ALUOut, and a single ALU reused across cycles.
- Replaces the single-cycle control unit when the datapath is converted to multi-cycle.
- Drives every datapath mux, write strobe and ALU_Control code.
- Waits on a memory ready handshake and flags illegal instructions and memory timeouts.

Parameters:
- MAX_WAIT, 255: maximum consecutive wait cycles on mem_ready before the access is aborted.
- WAIT_W, 8: width of the wait counter; must satisfy 2^WAIT_W > MAX_WAIT.

Ports:
- clk  input  1  single system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-high.
- opcode  input  6  IR[31:26]; IR is stable after FETCH.
- funct  input  6  IR[5:0].
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory completes the current read/write this cycle.
- pc_write  output  1  final PC load enable; branch condition already resolved internally.
- iord  output  1  0 = memory address from PC, 1 = address from ALUOut.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  IR load enable.
- reg_dst  output  1  1 = rd, 0 = rt.
- mem_to_reg  output  1  1 = MDR, 0 = ALUOut.
- reg_write  output  1  register file write enable.
- alu_src_a  output  1  0 = PC, 1 = register A.
- alu_src_b  output  2  00 = B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- ALU_Control  output  4  0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt, 1100 nor.
- pc_source  output  2  00 = ALU result, 01 = ALUOut, 10 = jump target.
- state  output  4  current state encoding, for debug.
- instr_done  output  1  one-cycle pulse on the cycle the FSM returns to FETCH after completing an instruction.
- illegal  output  1  sticky; set on an unsupported opcode or funct.
- bus_error  output  1  sticky; set on a memory timeout.

Behaviour:
- Reset (asynchronous):
  - state = FETCH (0), wait counter = 0, illegal = 0, bus_error = 0.
  - While reset is high, all strobes, instr_done, ALU_Control and mux selects are 0.
- Outputs not listed for a state are 0. ALU_Control defaults to 0010.
- FETCH (0):
  - Drives iord=0, mem_read=1, alu_src_a=0, alu_src_b=01, add.
  - ir_write=1 and pc_write=1 (pc_source=00) only in the cycle mem_ready=1; next state is DECODE.
  - Otherwise the FSM stays in FETCH.
- DECODE (1): alu_src_a=0, alu_src_b=11, add (branch target into ALUOut). Next state by opcode:
  - 000000 -> EXECUTE
  - 100011 or 101011 -> MEM_ADDR
  - 000100 -> BRANCH
  - 000010 -> JUMP (only with the optional feature)
  - anything else -> FETCH, illegal set to 1, instr_done=1.
- MEM_ADDR (2): alu_src_a=1, alu_src_b=10, add. Next state is MEM_READ for lw, MEM_WRITE for sw.
- MEM_READ (3): iord=1, mem_read=1. Waits for mem_ready, then goes to MEM_WB.
- MEM_WB (4): reg_dst=0, mem_to_reg=1, reg_write=1. Next state is FETCH.
- MEM_WRITE (5): iord=1, mem_write=1. Waits for mem_ready, then goes to FETCH.
- EXECUTE (6): alu_src_a=1, alu_src_b=00. funct decode:
  - 100000 -> 0010, 100010 -> 0110, 100100 -> 0000, 100101 -> 0001, 101010 -> 0111, 100111 -> 1100; next state ALU_WB.
  - Any other funct -> FETCH, illegal set to 1, no register write.
- ALU_WB (7): reg_dst=1, mem_to_reg=0, reg_write=1. Next state is FETCH.
- BRANCH (8): alu_src_a=1, alu_src_b=00, sub, pc_source=01, pc_write=zero. Next state is FETCH.
- instr_done: asserted on every transition into FETCH from a non-FETCH state.
- Latency with mem_ready held at 1:
  - R-type 4 cycles, lw 5, sw 4, beq 3, j 3.
  - Each wait cycle adds one cycle.
- Wait counter:
  - Increments on each cycle in FETCH, MEM_READ or MEM_WRITE with mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - When the count reaches MAX_WAIT with mem_ready still 0: abort the access, set bus_error, go to FETCH.
  - The abort asserts no pc_write, ir_write or reg_write.
  - instr_done pulses on the abort unless the aborted access was FETCH itself.
- illegal and bus_error are cleared only by reset.
- Reset mid-instruction: outputs drop to 0 immediately; no partial writeback occurs.

Optional Feature:
- Macro: MULTICYCLE_JUMP_EN.
- Defined:
  - opcode 000010 goes to JUMP (9).
  - JUMP drives pc_source=10 and pc_write=1, then goes to FETCH.
- Undefined:
  - State 9 does not exist.
  - opcode 000010 is treated as illegal.

Test Plan:
- Reset released, mem_ready=1, opcode=000000, funct=100000 -> state sequence 0,1,6,7,0; ALU_Control=0010 in state 6; reg_write=1 and reg_dst=1 only in state 7; instr_done pulses once.
- lw (100011) with mem_ready low for 3 cycles in MEM_READ -> state held at 3 for 4 cycles; MEM_WB has mem_to_reg=1; total 8 cycles.
- beq with zero=1 -> pc_write=1 and pc_source=01 in state 8; repeat with zero=0 -> pc_write stays 0.
- opcode 111111 -> DECODE then FETCH, illegal=1 and stays 1 through later valid instructions until reset.
- MAX_WAIT=4, mem_ready stuck at 0 in FETCH -> bus_error=1 after 4 wait cycles, ir_write never asserted, FSM returns to FETCH.
- Assert reset during MEM_WB -> reg_write drops to 0 the same cycle; state=0 after release.
